// File: rtl/mult_row_seq_pkg.sv
// Shared types and defaults for the row-reusing sequential multiplier.
package mult_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    ADD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_row_seq_if.sv
// Start/done handshake plus operand and product bus of the sequential multiplier.
interface mult_row_seq_if
  import mult_pkg::*;
#(
  parameter int N = MULT_N
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (output start, output a, output b, input busy, input done, input p);
  modport slave  (input start, input a, input b, output busy, output done, output p);
endinterface

// File: rtl/mult_row_seq_pp_row.sv
// One row of AND + full-adder partial-product cells, purely combinational.
module pp_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic si_i,
  input  logic ci_i,
  output logic so_o,
  output logic co_o
);
  logic x;

  assign x    = a_i & b_i;
  assign so_o = x ^ si_i ^ ci_i;
  assign co_o = (x & si_i) | (x & ci_i) | (si_i & ci_i);
endmodule

module pp_row #(
  parameter int N = 8
) (
  input  logic         a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] si_i,
  input  logic [N-1:0] ci_i,
  output logic [N-1:0] so_o,
  output logic [N-1:0] co_o
);
  for (genvar j = 0; j < N; j++) begin : g_cell
    pp_cell u_cell (
      .a_i  (a_i),
      .b_i  (b_i[j]),
      .si_i (si_i[j]),
      .ci_i (ci_i[j]),
      .so_o (so_o[j]),
      .co_o (co_o[j])
    );
  end
endmodule

// File: rtl/mult_row_seq.sv
// Unsigned N x N multiplier: one carry-save row reused for N cycles, then one
// carry-propagate cycle for the upper product half.
module mult_row_seq
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_row_seq_if.slave bus
);
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [N-1:0]   s_q, c_q;
  logic [N-1:0]   plo_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q;
  logic [2*N-1:0] p_q;

  logic [N-1:0]   si_d, so_d, co_d, hi_d;

  // The sum vector shifts down one weight per row; its top input is empty.
  assign si_d = {1'b0, s_q[N-1:1]};
  assign hi_d = si_d + c_q;

  pp_row #(.N(N)) u_row (
    .a_i  (a_q[cnt_q]),
    .b_i  (b_q),
    .si_i (si_d),
    .ci_i (c_q),
    .so_o (so_d),
    .co_o (co_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            s_q     <= '0;
            c_q     <= '0;
            plo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ROW;
          end
        end
        ROW: begin
          s_q          <= so_d;
          c_q          <= co_d;
          plo_q[cnt_q] <= so_d[0];
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= ADD;
        end
        ADD: begin
          p_q     <= {hi_d, plo_q};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;
endmodule

// File: tb/tb_mult_row_seq.sv
// Directed and table-driven bench for mult_row_seq at N=8 and N=4.
module tb_mult_row_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_row_seq_if #(.N(8)) bus8 ();
  mult_row_seq_if #(.N(4)) bus4 ();

  mult_row_seq #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mult_row_seq #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one N=8 operation from an idle DUT, return latency in edges after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    bit busy_ok = 1'b1;
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = ~a;
    bus8.b = ~b;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (bus8.done) break;
      if (bus8.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("busy_during_op", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, output int lat);
    bus4.start = 1'b1;
    bus4.a = a;
    bus4.b = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (bus4.done) break;
    end
  endtask

  initial begin
    int lat;
    int edges;
    logic [7:0] ra, rb;
    bit seen;

    vecs[0] = '{8'd13, 8'd11, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h80, 8'h80, 16'h4000};
    vecs[3] = '{8'h00, 8'hA5, 16'h0000};
    vecs[4] = '{8'h01, 8'hA5, 16'h00A5};
    vecs[5] = '{8'hA5, 8'h01, 16'h00A5};
    vecs[6] = '{8'h03, 8'h05, 16'h000F};
    vecs[7] = '{8'hFF, 8'h01, 16'h00FF};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus8.busy}, 32'd0);
    check("reset_done", {31'd0, bus8.done}, 32'd0);
    check("reset_p", {16'd0, bus8.p}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_p", i), {16'd0, bus8.p}, {16'd0, vecs[i].exp});
      check($sformatf("vec%0d_busy_in_done", i), {31'd0, bus8.busy}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_width", i), {31'd0, bus8.done}, 32'd0);
      check($sformatf("vec%0d_p_hold", i), {16'd0, bus8.p}, {16'd0, vecs[i].exp});
    end

    // start held high; operands scrambled while busy; next op accepted in done cycle
    bus8.start = 1'b1; bus8.a = 8'd6; bus8.b = 8'd7;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      @(posedge clk); #1;
      lat = i;
      if (bus8.done) break;
    end
    check("held_first_latency", lat, 9);
    check("held_first_p", {16'd0, bus8.p}, 32'd42);
    bus8.a = 8'd9; bus8.b = 8'd9;
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      edges = i;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      if (bus8.done) break;
    end
    bus8.start = 1'b0;
    check("held_second_spacing", edges, 10);
    check("held_second_p", {16'd0, bus8.p}, 32'd81);
    @(posedge clk); #1;
    check("held_idle_after_drop", {31'd0, bus8.busy}, 32'd0);

    // asynchronous abort at row 4
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus8.busy}, 32'd0);
    check("abort_p", {16'd0, bus8.p}, 32'd0);
    check("abort_done", {31'd0, bus8.done}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    op8(8'd3, 8'd5, lat);
    check("after_abort_latency", lat, 9);
    check("after_abort_p", {16'd0, bus8.p}, 32'd15);
    @(posedge clk); #1;

    // random sweep
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, lat);
      check("rand_latency", lat, 9);
      check("rand_p", {16'd0, bus8.p}, 32'(ra) * 32'(rb));
    end

    // N=4 build
    @(posedge clk); #1;
    op4(4'd15, 4'd15, lat);
    check("n4_latency", lat, 5);
    check("n4_p_225", {24'd0, bus4.p}, 32'd225);
    @(posedge clk); #1;
    check("n4_done_width", {31'd0, bus4.done}, 32'd0);
    op4(4'd6, 4'd11, lat);
    check("n4_p_66", {24'd0, bus4.p}, 32'd66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
